xmit_priority_sched: RTL and testbench
======================================

XMIT_PRIORITY_SCHED -- requirements
Module: xmit_priority_sched

Interface
REQ-001 SHALL have parameter LEN_W, default 12: frame-length field width in bytes.
REQ-002 SHALL have parameter IFG_CYCLES, default 12: idle cycles between frames.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4: consecutive hi grants allowed before a pending lo frame is forced.
REQ-004 SHALL have port clk_sys  in  1: sole clock, rising edge.
REQ-005 SHALL have port reset  in  1: synchronous, active-high reset on clk_sys.
REQ-006 SHALL have port hi_ctrl_empty  in  1: hi-priority control FIFO empty.
REQ-007 SHALL have port hi_ctrl_len  in  LEN_W: head-of-FIFO frame length; FIFO is first-word-fall-through, so the value is valid while hi_ctrl_empty=0.
REQ-008 SHALL have port lo_ctrl_empty  in  1, and port lo_ctrl_len  in  LEN_W: the same as REQ-006 and REQ-007 for lo priority.
REQ-009 SHALL have port tx_ready  in  1: downstream accepts one byte this cycle.
REQ-010 SHALL have ports hi_ctrl_rd  out  1 and lo_ctrl_rd  out  1: one-cycle pop strobes for the control FIFOs.
REQ-011 SHALL have ports hi_data_rd  out  1 and lo_data_rd  out  1: one-cycle pop strobes for the data FIFOs, one byte per strobe.
REQ-012 SHALL have port tx_sel  out  1: 1 = hi queue owns the datapath.
REQ-013 SHALL have ports tx_sof  out  1 and tx_eof  out  1: qualify the first and last data_rd of a frame.
REQ-014 SHALL have port tx_busy  out  1: high in SEND and GAP.

Function
REQ-015 SHALL implement an FSM with states IDLE, SEND and GAP.
REQ-016 IDLE arbitration: if either ctrl FIFO is non-empty, grant hi when hi is non-empty, otherwise grant lo; subject to REQ-021.
REQ-017 On a grant in IDLE, the block SHALL:
- assert the granted ctrl_rd for exactly one cycle;
- load hi_ctrl_len or lo_ctrl_len into a down-counter;
- latch tx_sel;
- go to SEND on the next cycle.
REQ-018 A granted length of 0 SHALL pop the ctrl FIFO, issue no data_rd, leave the starvation counter unchanged and remain in IDLE.
REQ-019 In SEND, each cycle with tx_ready=1 SHALL:
- assert the selected data_rd only;
- decrement the counter;
- assert tx_sof on the first byte and tx_eof on the byte where the counter is 1.
In SEND, a cycle with tx_ready=0 SHALL assert no strobes and hold all state.
REQ-020 After the eof byte the FSM SHALL enter GAP, hold for exactly IFG_CYCLES cycles, then return to IDLE. tx_sel SHALL hold its value through SEND and GAP.
REQ-021 Starvation counter:
- saturating, width clog2(STARVE_LIMIT+1);
- increments on each hi grant and clears on each lo grant;
- when it equals STARVE_LIMIT and lo is non-empty, IDLE SHALL grant lo even when hi is non-empty.
REQ-022 Latency: a grant in IDLE at cycle N gives the first data_rd at cycle N+1 when tx_ready=1.
REQ-023 A frame of L bytes SHALL produce exactly L data_rd strobes. hi_data_rd and lo_data_rd SHALL never be asserted in the same cycle, and neither SHALL be asserted outside SEND.
REQ-024 Arrivals during SEND or GAP SHALL be ignored until IDLE. A simultaneous hi and lo arrival is resolved by REQ-016 and REQ-021.
REQ-025 A length of 2^LEN_W-1 SHALL be handled without counter wrap.

Reset
REQ-026 While reset=1 the block SHALL hold:
- state IDLE;
- counters 0;
- all outputs 0, including tx_sel.
REQ-027 Reset asserted mid-SEND or mid-GAP SHALL abort the frame at the next edge with no further strobes. Draining the remaining FIFO data is the upstream's responsibility.

Configuration
REQ-028 Macro XMIT_STARVE_GUARD_EN:
- when defined, REQ-021 applies;
- when undefined, arbitration is strict priority (hi always wins) and no starvation counter is synthesized.

Verification
REQ-029 Lo only, len=64, tx_ready=1 -> lo_ctrl_rd for 1 cycle; 64 lo_data_rd with sof on byte 1 and eof on byte 64; GAP lasts 12 cycles; tx_sel=0.
REQ-030 Hi and lo both non-empty, len=512 each, guard defined -> four hi frames, then one lo frame, then hi again. Guard undefined -> hi frames only while hi remains non-empty.
REQ-031 Hi frame len=8 with tx_ready toggled 1,0,1,0 -> exactly 8 hi_data_rd strobes, none while tx_ready=0; eof coincides with the 8th strobe.
REQ-032 Reset pulsed for 1 cycle at byte 100 of a 512-byte frame -> all outputs 0 on the next cycle, state IDLE; a new grant is possible on the cycle after reset falls.
REQ-033 Hi len=0 followed by hi len=64 -> two hi_ctrl_rd strobes, 64 data_rd strobes, a single sof and a single eof.

Source files
------------

// File: rtl/xmit_priority_sched_if.sv
// Control/data FIFO and transmit handshake bundle for the two-queue transmit scheduler.
// master = scheduler side, slave = FIFO/downstream side.
interface xmit_priority_sched_if #(
    parameter int LEN_W = 12
) ();
    logic             hi_ctrl_empty;
    logic [LEN_W-1:0] hi_ctrl_len;
    logic             lo_ctrl_empty;
    logic [LEN_W-1:0] lo_ctrl_len;
    logic             tx_ready;
    logic             hi_ctrl_rd;
    logic             lo_ctrl_rd;
    logic             hi_data_rd;
    logic             lo_data_rd;
    logic             tx_sel;
    logic             tx_sof;
    logic             tx_eof;
    logic             tx_busy;

    modport master (
        input  hi_ctrl_empty, hi_ctrl_len, lo_ctrl_empty, lo_ctrl_len, tx_ready,
        output hi_ctrl_rd, lo_ctrl_rd, hi_data_rd, lo_data_rd,
        output tx_sel, tx_sof, tx_eof, tx_busy
    );

    modport slave (
        output hi_ctrl_empty, hi_ctrl_len, lo_ctrl_empty, lo_ctrl_len, tx_ready,
        input  hi_ctrl_rd, lo_ctrl_rd, hi_data_rd, lo_data_rd,
        input  tx_sel, tx_sof, tx_eof, tx_busy
    );
endinterface

// File: rtl/xmit_priority_sched.sv
// Two-queue (hi/lo) frame transmit scheduler with an inter-frame gap (IDLE/SEND/GAP FSM).
// Optional lo-queue starvation guard enabled by defining XMIT_STARVE_GUARD_EN.
module xmit_priority_sched #(
    parameter int LEN_W        = 12,
    parameter int IFG_CYCLES   = 12,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    xmit_priority_sched_if.master bus
);

    localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (IFG_CYCLES > 0) ? GAP_W'(IFG_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [LEN_W-1:0]   cnt_r, cnt_s;
    logic [GAP_W-1:0]   gap_r, gap_s;
    logic               sel_r, sel_s;
    logic               first_r, first_s;

    logic               grant_hi_s;
    logic               grant_lo_s;
    logic [LEN_W-1:0]   grant_len_s;
    logic               hi_ctrl_rd_s;
    logic               lo_ctrl_rd_s;
    logic               hi_data_rd_s;
    logic               lo_data_rd_s;
    logic               sof_s;
    logic               eof_s;

`ifdef XMIT_STARVE_GUARD_EN
    localparam int SV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SV_W-1:0] STARVE_MAX = SV_W'(STARVE_LIMIT);

    logic [SV_W-1:0] starve_r, starve_s;

    // Arbitration: a pending lo frame preempts hi once the hi run reaches the limit.
    always_comb begin
        grant_hi_s = 1'b0;
        grant_lo_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (!bus.lo_ctrl_empty && (starve_r == STARVE_MAX)) begin
                grant_lo_s = 1'b1;
            end else if (!bus.hi_ctrl_empty) begin
                grant_hi_s = 1'b1;
            end else if (!bus.lo_ctrl_empty) begin
                grant_lo_s = 1'b1;
            end else begin
                grant_hi_s = 1'b0;
            end
        end else begin
            grant_hi_s = 1'b0;
        end
    end

    // Starvation count: zero-length frames move no data and so leave it untouched.
    always_comb begin
        starve_s = starve_r;
        if ((state_r == ST_IDLE) && (grant_len_s != '0)) begin
            if (grant_lo_s) begin
                starve_s = '0;
            end else if (grant_hi_s && (starve_r < STARVE_MAX)) begin
                starve_s = starve_r + SV_W'(1);
            end else begin
                starve_s = starve_r;
            end
        end else begin
            starve_s = starve_r;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            starve_r <= '0;
        end else begin
            starve_r <= starve_s;
        end
    end
`else
    // Arbitration: strict priority, hi always wins.
    always_comb begin
        grant_hi_s = 1'b0;
        grant_lo_s = 1'b0;
        if (state_r == ST_IDLE) begin
            if (!bus.hi_ctrl_empty) begin
                grant_hi_s = 1'b1;
            end else if (!bus.lo_ctrl_empty) begin
                grant_lo_s = 1'b1;
            end else begin
                grant_hi_s = 1'b0;
            end
        end else begin
            grant_hi_s = 1'b0;
        end
    end
`endif

    // Length of the frame at the head of the granted queue.
    always_comb begin
        grant_len_s = '0;
        if (grant_hi_s) begin
            grant_len_s = bus.hi_ctrl_len;
        end else if (grant_lo_s) begin
            grant_len_s = bus.lo_ctrl_len;
        end else begin
            grant_len_s = '0;
        end
    end

    // FSM next-state, datapath next-values and strobes.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        gap_s        = gap_r;
        sel_s        = sel_r;
        first_s      = first_r;
        hi_ctrl_rd_s = 1'b0;
        lo_ctrl_rd_s = 1'b0;
        hi_data_rd_s = 1'b0;
        lo_data_rd_s = 1'b0;
        sof_s        = 1'b0;
        eof_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                hi_ctrl_rd_s = grant_hi_s;
                lo_ctrl_rd_s = grant_lo_s;
                // A zero-length entry is just discarded; stay here to arbitrate again.
                if ((grant_hi_s || grant_lo_s) && (grant_len_s != '0)) begin
                    state_s = ST_SEND;
                    cnt_s   = grant_len_s;
                    sel_s   = grant_hi_s;
                    first_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (bus.tx_ready) begin
                    hi_data_rd_s = sel_r;
                    lo_data_rd_s = ~sel_r;
                    sof_s        = first_r;
                    eof_s        = (cnt_r == LEN_W'(1));
                    cnt_s        = cnt_r - LEN_W'(1);
                    first_s      = 1'b0;
                    if (eof_s) begin
                        gap_s   = GAP_LOAD;
                        state_s = (IFG_CYCLES > 0) ? ST_GAP : ST_IDLE;
                    end else begin
                        state_s = ST_SEND;
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_GAP: begin
                if (gap_r == '0) begin
                    state_s = ST_IDLE;
                end else begin
                    gap_s = gap_r - GAP_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            gap_r   <= '0;
            sel_r   <= 1'b0;
            first_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            gap_r   <= gap_s;
            sel_r   <= sel_s;
            first_r <= first_s;
        end
    end

    // Every output is forced low while reset is held, even before the first edge.
    assign bus.hi_ctrl_rd = hi_ctrl_rd_s & ~reset;
    assign bus.lo_ctrl_rd = lo_ctrl_rd_s & ~reset;
    assign bus.hi_data_rd = hi_data_rd_s & ~reset;
    assign bus.lo_data_rd = lo_data_rd_s & ~reset;
    assign bus.tx_sof     = sof_s & ~reset;
    assign bus.tx_eof     = eof_s & ~reset;
    assign bus.tx_sel     = sel_r & ~reset;
    assign bus.tx_busy    = (state_r != ST_IDLE) & ~reset;

endmodule

// File: tb/tb_xmit_priority_sched.sv
// Directed self-checking bench for xmit_priority_sched with behavioural FWFT control FIFOs.
module tb_xmit_priority_sched;

    logic clk_sys;
    logic reset;

    xmit_priority_sched_if #(.LEN_W(12)) bus ();

    xmit_priority_sched #(
        .LEN_W(12),
        .IFG_CYCLES(12),
        .STARVE_LIMIT(4)
    ) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .bus(bus)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    int checks = 0;
    int errors = 0;

    logic [11:0] hi_q[$];
    logic [11:0] lo_q[$];
    logic        grants[$];

    logic o_hcr, o_lcr, o_hdr, o_ldr, o_sof, o_eof, o_sel, o_busy;
    int   n_hcr, n_lcr, n_hdr, n_ldr, n_sof, n_eof, n_bad;

    task automatic apply_fifo();
        bus.hi_ctrl_empty = (hi_q.size() == 0);
        bus.hi_ctrl_len   = (hi_q.size() != 0) ? hi_q[0] : 12'd0;
        bus.lo_ctrl_empty = (lo_q.size() == 0);
        bus.lo_ctrl_len   = (lo_q.size() != 0) ? lo_q[0] : 12'd0;
    endtask

    task automatic clear_counts();
        n_hcr = 0; n_lcr = 0; n_hdr = 0; n_ldr = 0;
        n_sof = 0; n_eof = 0; n_bad = 0;
        grants.delete();
    endtask

    // Sample one cycle mid-period, then cross the edge and pop the FIFO models.
    task automatic step();
        #2;
        o_hcr  = bus.hi_ctrl_rd;  o_lcr = bus.lo_ctrl_rd;
        o_hdr  = bus.hi_data_rd;  o_ldr = bus.lo_data_rd;
        o_sof  = bus.tx_sof;      o_eof = bus.tx_eof;
        o_sel  = bus.tx_sel;      o_busy = bus.tx_busy;
        n_hcr += int'(o_hcr); n_lcr += int'(o_lcr);
        n_hdr += int'(o_hdr); n_ldr += int'(o_ldr);
        n_sof += int'(o_sof); n_eof += int'(o_eof);
        if (o_hdr && o_ldr) n_bad++;
        if ((o_hdr || o_ldr) && !o_busy) n_bad++;
        if (o_hcr) grants.push_back(1'b1);
        if (o_lcr) grants.push_back(1'b0);
        @(posedge clk_sys);
        #1;
        if (o_hcr && hi_q.size() != 0) void'(hi_q.pop_front());
        if (o_lcr && lo_q.size() != 0) void'(lo_q.pop_front());
        apply_fifo();
    endtask

    task automatic run_until_idle(input int max_cycles);
        int k;
        k = 0;
        while (k < max_cycles) begin
            step();
            k++;
            if (!o_busy && !o_hcr && !o_lcr && hi_q.size() == 0 && lo_q.size() == 0) break;
        end
        checks++;
        if (k >= max_cycles) begin
            errors++;
            $display("FAIL idle_timeout: ran %0d cycles, required fewer than %0d", k, max_cycles);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tx_ready_set(1'b1);
        hi_q.push_back(12'd5);
        apply_fifo();
        step();
        step();
        checks++;
        if ({o_hcr, o_lcr, o_hdr, o_ldr, o_sof, o_eof, o_sel, o_busy} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 00000000",
                     {o_hcr, o_lcr, o_hdr, o_ldr, o_sof, o_eof, o_sel, o_busy});
        end
        checks++;
        if (hi_q.size() != 1) begin
            errors++;
            $display("FAIL reset_no_pop: fifo depth %0d required 1", hi_q.size());
        end
        hi_q.delete();
        apply_fifo();
        reset = 1'b0;
        step();
        checks++;
        if ({o_hcr, o_busy, o_sel} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: hcr/busy/sel %b required 000", {o_hcr, o_busy, o_sel});
        end
    endtask

    task automatic tx_ready_set(input logic v);
        bus.tx_ready = v;
    endtask

    task automatic test_lo_frame();
        clear_counts();
        tx_ready_set(1'b1);
        lo_q.push_back(12'd64);
        apply_fifo();
        step();
        checks++;
        if ({o_lcr, o_hcr, o_ldr, o_busy} !== 4'b1000) begin
            errors++;
            $display("FAIL lo_grant: lcr/hcr/ldr/busy %b required 1000", {o_lcr, o_hcr, o_ldr, o_busy});
        end
        for (int i = 1; i <= 64; i++) begin
            step();
            checks++;
            if ({o_ldr, o_hdr, o_sof, o_eof, o_sel, o_busy} !== {1'b1, 1'b0, (i == 1), (i == 64), 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL lo_byte%0d: ldr/hdr/sof/eof/sel/busy %b required %b", i,
                         {o_ldr, o_hdr, o_sof, o_eof, o_sel, o_busy},
                         {1'b1, 1'b0, (i == 1), (i == 64), 1'b0, 1'b1});
            end
        end
        for (int g = 0; g < 12; g++) begin
            step();
            checks++;
            if ({o_busy, o_hdr, o_ldr, o_sel, o_lcr} !== 5'b10000) begin
                errors++;
                $display("FAIL lo_gap%0d: busy/hdr/ldr/sel/lcr %b required 10000", g,
                         {o_busy, o_hdr, o_ldr, o_sel, o_lcr});
            end
        end
        step();
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL lo_gap_end: busy %b required 0", o_busy);
        end
        checks++;
        if (n_ldr != 64 || n_lcr != 1 || n_bad != 0) begin
            errors++;
            $display("FAIL lo_totals: ldr %0d lcr %0d bad %0d required 64 1 0", n_ldr, n_lcr, n_bad);
        end
    endtask

    task automatic test_ready_toggle();
        int k;
        clear_counts();
        tx_ready_set(1'b1);
        hi_q.push_back(12'd8);
        apply_fifo();
        step();
        k = 0;
        while (n_hdr < 8 && k < 40) begin
            tx_ready_set((k % 2) == 0);
            step();
            checks++;
            if (!bus.tx_ready && (o_hdr || o_ldr || o_sof || o_eof)) begin
                errors++;
                $display("FAIL toggle_stall%0d: strobes %b required 0000", k, {o_hdr, o_ldr, o_sof, o_eof});
            end else if (bus.tx_ready && ({o_hdr, o_eof} !== {1'b1, (n_hdr == 8)})) begin
                errors++;
                $display("FAIL toggle_byte%0d: hdr/eof %b required %b", k, {o_hdr, o_eof}, {1'b1, (n_hdr == 8)});
            end
            k++;
        end
        checks++;
        if (n_hdr != 8 || n_eof != 1 || n_sof != 1 || k != 15) begin
            errors++;
            $display("FAIL toggle_totals: hdr %0d eof %0d sof %0d cycles %0d required 8 1 1 15", n_hdr, n_eof, n_sof, k);
        end
        tx_ready_set(1'b1);
        run_until_idle(100);
    endtask

    task automatic test_zero_len();
        clear_counts();
        tx_ready_set(1'b1);
        hi_q.push_back(12'd0);
        hi_q.push_back(12'd64);
        apply_fifo();
        step();
        checks++;
        if ({o_hcr, o_busy} !== 2'b10) begin
            errors++;
            $display("FAIL zero_first: hcr/busy %b required 10", {o_hcr, o_busy});
        end
        step();
        checks++;
        if ({o_hcr, o_busy, o_hdr} !== 3'b100) begin
            errors++;
            $display("FAIL zero_second: hcr/busy/hdr %b required 100", {o_hcr, o_busy, o_hdr});
        end
        run_until_idle(200);
        checks++;
        if (n_hcr != 2 || n_hdr != 64 || n_ldr != 0 || n_sof != 1 || n_eof != 1 || n_bad != 0) begin
            errors++;
            $display("FAIL zero_totals: hcr %0d hdr %0d ldr %0d sof %0d eof %0d bad %0d required 2 64 0 1 1 0",
                     n_hcr, n_hdr, n_ldr, n_sof, n_eof, n_bad);
        end
    endtask

    task automatic test_reset_mid_frame();
        clear_counts();
        tx_ready_set(1'b1);
        hi_q.push_back(12'd512);
        apply_fifo();
        step();
        for (int i = 1; i <= 99; i++) step();
        checks++;
        if (n_hdr != 99) begin
            errors++;
            $display("FAIL abort_pre: hdr %0d required 99", n_hdr);
        end
        reset = 1'b1;
        step();
        checks++;
        if ({o_hcr, o_lcr, o_hdr, o_ldr, o_sof, o_eof, o_sel, o_busy} !== 8'h00) begin
            errors++;
            $display("FAIL abort_reset: outputs %b required 00000000",
                     {o_hcr, o_lcr, o_hdr, o_ldr, o_sof, o_eof, o_sel, o_busy});
        end
        reset = 1'b0;
        hi_q.push_back(12'd16);
        apply_fifo();
        step();
        checks++;
        if ({o_hcr, o_busy, o_hdr} !== 3'b100) begin
            errors++;
            $display("FAIL abort_regrant: hcr/busy/hdr %b required 100", {o_hcr, o_busy, o_hdr});
        end
        run_until_idle(100);
        checks++;
        if (n_hdr != 115 || n_sof != 2 || n_eof != 1) begin
            errors++;
            $display("FAIL abort_totals: hdr %0d sof %0d eof %0d required 115 2 1", n_hdr, n_sof, n_eof);
        end
    endtask

    task automatic test_starvation();
        logic [6:0] exp;
`ifdef XMIT_STARVE_GUARD_EN
        exp = 7'b1111011;
`else
        exp = 7'b1111110;
`endif
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_counts();
        tx_ready_set(1'b1);
        for (int i = 0; i < 6; i++) hi_q.push_back(12'd512);
        lo_q.push_back(12'd512);
        apply_fifo();
        run_until_idle(10000);
        checks++;
        if (grants.size() != 7) begin
            errors++;
            $display("FAIL starve_count: grants %0d required 7", grants.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (grants[i] !== exp[6-i]) begin
                    errors++;
                    $display("FAIL starve_order%0d: hi_grant %b required %b", i, grants[i], exp[6-i]);
                end
            end
        end
        checks++;
        if (n_hdr != 3072 || n_ldr != 512 || n_bad != 0) begin
            errors++;
            $display("FAIL starve_totals: hdr %0d ldr %0d bad %0d required 3072 512 0", n_hdr, n_ldr, n_bad);
        end
    endtask

    task automatic test_max_len();
        clear_counts();
        tx_ready_set(1'b1);
        hi_q.push_back(12'd4095);
        apply_fifo();
        run_until_idle(5000);
        checks++;
        if (n_hdr != 4095 || n_sof != 1 || n_eof != 1) begin
            errors++;
            $display("FAIL max_len: hdr %0d sof %0d eof %0d required 4095 1 1", n_hdr, n_sof, n_eof);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.tx_ready = 1'b0;
        apply_fifo();
        clear_counts();
        @(posedge clk_sys);
        #1;
        test_reset();
        test_lo_frame();
        test_ready_toggle();
        test_zero_len();
        test_reset_mid_frame();
        test_starvation();
        test_max_len();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
